// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory load sequencer: load funct3 codes,
// FSM state encoding and the word-crossing (split) detector.
package dm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_CAP  = 3'd3,
        ST_RESP = 3'd4
    } dm_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic funct3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // True when the access touches bytes of the following word.
    function automatic logic split_needed(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == F3_LW) && (off != 2'd0)) ||
               (((f3 == F3_LH) || (f3 == F3_LHU)) && (off == 2'd3));
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// Byte selection, little-endian assembly and sign/zero extension of a load,
// taken from a 64-bit window whose byte j sits at bits [63-8j -: 8].
module load_align_extend
    import dm_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0] byte_sel [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        logic [2:0] idx;
        assign idx = {1'b0, offset} + 3'(gi);
        assign byte_sel[gi] = window[8*(7-idx) +: 8];
    end

    always_comb begin
        result = '0;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[0][7]}}, byte_sel[0]};
            F3_LH:   result = {{16{byte_sel[1][7]}}, byte_sel[1], byte_sel[0]};
            F3_LW:   result = {byte_sel[3], byte_sel[2], byte_sel[1], byte_sel[0]};
            F3_LBU:  result = {24'h0, byte_sel[0]};
            F3_LHU:  result = {16'h0, byte_sel[1], byte_sel[0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/dm_load_sequencer.sv
// Load sequencer between the core load port and a synchronous BRAM data memory.
// Define DM_MISALIGNED_SPLIT_EN to service word-crossing loads with two reads.
module dm_load_sequencer
    import dm_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [2:0]        req_funct3,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    dm_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] word_addr_reg;
    logic [1:0]        offset_reg;
    logic [2:0]        funct3_reg;
    logic [31:0]       rsp_data_reg;
    logic              rsp_err_reg;
    logic              req_err;
    logic              accept;
    logic [63:0]       window;
    logic [31:0]       load_result;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

`ifdef DM_MISALIGNED_SPLIT_EN
    logic [31:0] lo_word_reg;
    logic        split;

    assign split   = split_needed(funct3_reg, offset_reg);
    assign req_err = !funct3_legal(req_funct3);
    assign window  = split ? {lo_word_reg, mem_rdata} : {mem_rdata, 32'h0};
`else
    // Without the two-read path a word-crossing load is rejected up front.
    assign req_err = !funct3_legal(req_funct3) || split_needed(req_funct3, req_addr[1:0]);
    assign window  = {mem_rdata, 32'h0};
`endif

    assign accept = (state_reg == ST_IDLE) && req_valid;

    load_align_extend u_align (
        .window (window),
        .offset (offset_reg),
        .funct3 (funct3_reg),
        .result (load_result)
    );

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        rsp_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_err ? ST_RESP : ST_RD0;
            end
            ST_RD0: begin
                mem_rd_en = 1'b1;
                mem_addr  = word_addr_reg;
`ifdef DM_MISALIGNED_SPLIT_EN
                state_next = split ? ST_RD1 : ST_CAP;
`else
                state_next = ST_CAP;
`endif
            end
`ifdef DM_MISALIGNED_SPLIT_EN
            ST_RD1: begin
                mem_rd_en  = 1'b1;
                mem_addr   = word_addr_reg + ADDR_W'(1);
                state_next = ST_CAP;
            end
`endif
            ST_CAP:  state_next = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg     <= ST_IDLE;
            word_addr_reg <= '0;
            offset_reg    <= '0;
            funct3_reg    <= '0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                word_addr_reg <= req_addr[ADDR_W+1:2];
                offset_reg    <= req_addr[1:0];
                funct3_reg    <= req_funct3;
                rsp_data_reg  <= '0;
                rsp_err_reg   <= req_err;
            end
            if (state_reg == ST_CAP) rsp_data_reg <= load_result;
        end
    end

`ifdef DM_MISALIGNED_SPLIT_EN
    // The first word returns during RD1 while the second read is in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) lo_word_reg <= '0;
        else if (state_reg == ST_RD1) lo_word_reg <= mem_rdata;
    end
`endif

    assign rsp_data = rsp_data_reg;
    assign rsp_err  = rsp_err_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dm_load_sequencer.sv
// Randomized bench for dm_load_sequencer against a byte-addressed reference model.
// Honours DM_MISALIGNED_SPLIT_EN the same way as the design.
module tb_dm_load_sequencer;

    localparam int AW = 10;
    localparam int NWORDS = 1 << AW;
`ifdef DM_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic          clk;
    logic          nrst;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [2:0]    req_funct3;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          busy;

    logic [31:0] mem [NWORDS];
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] last_data;
    logic        last_err;

    dm_load_sequencer #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read BRAM.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input int unsigned ba);
        logic [31:0] w;
        int unsigned k;
        w = mem[(ba % (NWORDS * 4)) / 4];
        k = ba % 4;
        return w[31-8*k -: 8];
    endfunction

    // Reference: bytes read at successive byte addresses, assembled with plain arithmetic.
    task automatic model(input logic [31:0] a, input logic [2:0] f3,
                         output logic [31:0] data, output logic err,
                         output int lat, output int nreads);
        int size;
        bit legal, split;
        longint unsigned val;
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                (f3 == 3'b100) || (f3 == 3'b101);
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        split = (int'(a[1:0]) + size) > 4;
        if (!legal || (split && !SPLIT_EN)) begin
            data = 32'h0; err = 1'b1; lat = 1; nreads = 0;
        end else begin
            val = 0;
            for (int i = 0; i < size; i++)
                val += longint'(mem_byte(int'(a[11:0]) + i)) << (8 * i);
            if (!f3[2] && size < 4 && val >= (64'd1 << (8 * size - 1)))
                val += 64'h1_0000_0000 - (64'd1 << (8 * size));
            data = val[31:0]; err = 1'b0;
            lat = split ? 4 : 3; nreads = split ? 2 : 1;
        end
    endtask

    task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input int hold);
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat, exp_reads, n, reads;
        bit          seen;
        model(a, f3, exp_data, exp_err, exp_lat, exp_reads);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_funct3 = f3; rsp_ready = 1'b0;
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        // Garbage on the request port while busy must have no effect.
        req_addr = $urandom; req_funct3 = 3'($urandom_range(0, 7));
        n = 0; reads = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_rd_en) begin
                check_eq("rd_addr", 32'(mem_addr), 32'((int'(a[11:2]) + reads) % NWORDS));
                reads++;
            end
            if (rsp_valid) seen = 1'b1;
            else check_eq("req_ready_busy", 32'(req_ready), 32'd0);
        end
        check_eq("rsp_timeout", 32'(rsp_valid), 32'd1);
        check_eq("latency", 32'(n), 32'(exp_lat));
        check_eq("nreads", 32'(reads), 32'(exp_reads));
        check_eq("rsp_data", rsp_data, exp_data);
        check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
        last_data = rsp_data; last_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_data", rsp_data, exp_data);
            check_eq("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("post_hs_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_hs_ready", 32'(req_ready), 32'd1);
        check_eq("post_hs_busy", 32'(busy), 32'd0);
        $display("load addr=0x%08h f3=%03b data=0x%08h err=%0b lat=%0d hold=%0d",
                 a, f3, last_data, last_err, n, hold);
    endtask

    task automatic reset_during(input logic [31:0] a, input int cyc);
        bit any_valid;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (cyc) @(negedge clk);
        check_eq("pre_rst_rd_en", 32'(mem_rd_en), 32'd1);
        #1 nrst = 1'b0;
        #1;
        check_eq("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        nrst = 1'b1;
        any_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            any_valid |= rsp_valid;
        end
        check_eq("rst_no_rsp", 32'(any_valid), 32'd0);
        $display("reset during access addr=0x%08h cycle=%0d", a, cyc);
    endtask

    initial begin
        logic [31:0] a;
        nrst = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; rsp_ready = 1'b0;
        for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
        mem[4] = 32'h11223344; mem[5] = 32'h8899AABB;
        #2;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", rsp_data, 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_busy0", 32'(busy), 32'd0);
        check_eq("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        run_load(32'h10, 3'b010, 0);
        check_eq("tp_lw", last_data, 32'h44332211);
        run_load(32'h10, 3'b010, 3);
        check_eq("tp_lw_hold", last_data, 32'h44332211);
        mem[4] = 32'h11823344;
        run_load(32'h11, 3'b000, 1);
        check_eq("tp_lb", last_data, 32'hFFFFFF82);
        run_load(32'h11, 3'b100, 0);
        check_eq("tp_lbu", last_data, 32'h00000082);
        run_load(32'h10, 3'b101, 0);
        check_eq("tp_lhu", last_data, 32'h00008211);
        mem[4] = 32'h11223344;
        run_load(32'h11, 3'b001, 0);
        check_eq("tp_lh_off1", last_data, 32'h00003322);
        run_load(32'h12, 3'b010, 2);
        run_load(32'h13, 3'b001, 0);
        run_load(32'hFFE, 3'b010, 0);
        run_load(32'h10, 3'b011, 1);
        check_eq("tp_illegal_err", 32'(last_err), 32'd1);

        reset_during(32'h10, 1);
`ifdef DM_MISALIGNED_SPLIT_EN
        reset_during(32'h12, 2);
`endif
        run_load(32'h10, 3'b010, 0);
        check_eq("tp_after_rst", last_data, 32'h44332211);

        for (int t = 0; t < 80; t++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[11:3] = 9'h1FF;
            run_load(a, 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_load_sequencer.md
Name: dm_load_sequencer

Overview:
- Controller between the scalar core's load request port and the synchronous BRAM data memory.
- Accepts one load request at a time and issues one or two word reads. Two reads are used when a misaligned access crosses a word boundary.
- Merges the returned words and selects, orders and extends bytes per funct3.
- Returns the register-file value through a valid/ready response handshake.

Parameters:
ADDR_W, 10, word-address width of data memory (byte address bits [ADDR_W+1:2])

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
req_valid  in  1  load request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_addr  in  32  byte address
req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
mem_rd_en  out  1  BRAM read enable; data valid on mem_rdata next cycle
mem_addr  out  ADDR_W  BRAM word address
mem_rdata  in  32  BRAM read data; byte offset k occupies bits [31-8k -: 8]
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response consumer ready
rsp_data  out  32  loaded, extended value
rsp_err  out  1  illegal funct3 or unsupported misalignment; qualified by rsp_valid
busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - State IDLE.
  - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
  - mem_rd_en=0, mem_addr=0.
  - req_ready=1.
  - Reset is asynchronous and can occur in any state. It aborts the access immediately, and mem_rd_en drops with nrst.
- Outputs are combinational from state; rsp_data and rsp_err come from registers.
- States and transitions:
  - IDLE: req_ready=1. On accept, latch addr and funct3.
    - Illegal funct3 (011, 110, 111), or split needed with the option disabled: go to RESP with rsp_err=1 and rsp_data=0. No memory read is issued.
    - Otherwise go to RD0.
  - RD0: mem_rd_en=1, mem_addr=W (W = addr[ADDR_W+1:2]). Go to RD1 if split, else to CAP.
  - RD1: mem_rd_en=1, mem_addr=W+1 (modulo 2^ADDR_W, so it wraps to 0). Register mem_rdata into lo_word. Go to CAP.
  - CAP: build a 64-bit window.
    - Split: {lo_word, mem_rdata}.
    - No split: {mem_rdata, 32'h0}.
    - Extract bytes b0..bN starting at window byte offset addr[1:0].
    - Assemble little-endian {b3,b2,b1,b0}.
    - Sign-extend (LB, LH) or zero-extend (LBU, LHU) from the top loaded byte.
    - Register the result into rsp_data and go to RESP.
  - RESP: rsp_valid=1. rsp_data and rsp_err are held stable while rsp_ready=0. When rsp_ready=1, go to IDLE.
- Throughput: no request is accepted in RESP. The next accept is possible in the cycle after the handshake.
- Split condition: LW with addr[1:0]≠0, or LH/LHU with addr[1:0]=3. LH at offset 1 stays within the word and needs no split.
- Latency, accept at cycle T, rsp_valid rises at:
  - Aligned or non-split access: T+3.
  - Split access: T+4.
  - Error: T+1.
- req_valid and req_addr are ignored outside IDLE. Changes to them after accept have no effect.

Optional Feature:
DM_MISALIGNED_SPLIT_EN
- Defined: word-crossing accesses use the two-read RD0→RD1→CAP path.
- Undefined: a word-crossing access responds with rsp_err=1 and rsp_data=0 at T+1. The RD1 state and the lo_word register are not generated.

Decomposition:
- Package dm_pkg:
  - funct3 constants LB/LH/LW/LBU/LHU.
  - State encoding IDLE/RD0/RD1/CAP/RESP.
  - Split-detect function.
- One sub-module, load_align_extend: combinational. Takes the 64-bit window, offset and funct3; produces the 32-bit result. It is reusable by the vector LSU.

Test Plan:
1. Memory word4=0x11223344; LW 0x10 → mem_addr=4 at T+1; rsp_data=0x44332211, rsp_err=0, rsp_valid at T+3.
2. Word4=0x11823344; LB 0x11 → 0xFFFFFF82; LBU 0x11 → 0x00000082; LHU 0x10 → 0x00008211.
3. Option on; word4=0x11223344, word5=0x8899AABB.
   - LW 0x12 → reads word4 (T+1) and word5 (T+2); rsp_data=0x99884433 at T+4.
   - LH 0x13 → 0xFFFF8844.
   - With ADDR_W=10, LW 0xFFE → second read at mem_addr=0 (wrap).
4. funct3=011 at 0x10 → no mem_rd_en; rsp_valid at T+1 with rsp_err=1 and rsp_data=0. With the option off, LW 0x12 gives the same error response.
5. Hold rsp_ready=0 for 3 cycles after LW 0x10 → rsp_valid and rsp_data=0x44332211 stable; req_valid held high with req_ready=0 throughout; next request accepted in the cycle after the handshake.
6. Assert nrst during RD1 of split LW 0x12 → mem_rd_en and busy drop immediately; state IDLE; no rsp_valid; a following LW 0x10 completes normally.
